// File: rtl/rf_pkg.sv
// ============================================================================
// Package  : rf_pkg
// Brief    : Shared widths, types and helpers for the multi-port register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;
    localparam int RF_AW    = $clog2(RF_NREGS);

    typedef logic [RF_AW-1:0]   rf_addr_t;
    typedef logic [RF_XLEN-1:0] rf_data_t;

    // Address width for a register count; a two-entry file still needs one bit.
    function automatic int rf_addr_width(input int nregs);
        return (nregs > 2) ? $clog2(nregs) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
// Module   : rf_scoreboard
// Brief    : Per-register busy bits for pending long-latency writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int NREGS  = RF_NREGS,
    parameter  int NUM_WR = 1,
    localparam int AW     = rf_addr_width(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_valid_i,
    input  logic [AW-1:0]        set_addr_i,
    input  logic [NUM_WR-1:0]    wr_en_i,
    input  logic [NUM_WR*AW-1:0] wr_addr_i,
    input  logic                 flush_i,
    output logic [NREGS-1:0]     busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;

    // A new producer supersedes a retiring one; a squash overrides everything.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_valid_i) begin
            set_vec[set_addr_i] = 1'b1;
        end
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en_i[i]) begin
                clr_vec[wr_addr_i[i*AW +: AW]] = 1'b1;
            end
        end
        busy_d = (busy_q & ~clr_vec) | set_vec;
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module   : regfile_mp
// Brief    : Multi-port integer register file with write bypass and scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp
    import rf_pkg::*;
#(
    parameter  int XLEN   = RF_XLEN,
    parameter  int NREGS  = RF_NREGS,
    parameter  int NUM_RD = 2,
    parameter  int NUM_WR = 1,
    parameter  int BYPASS = 1,
    localparam int AW     = rf_addr_width(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_RD*AW-1:0]   rd_addr_i,
    output logic [NUM_RD*XLEN-1:0] rd_data_o,
    output logic [NUM_RD-1:0]      rd_busy_o,
    input  logic [NUM_WR-1:0]      wr_en_i,
    input  logic [NUM_WR*AW-1:0]   wr_addr_i,
    input  logic [NUM_WR*XLEN-1:0] wr_data_i,
    input  logic                   iss_valid_i,
    input  logic [AW-1:0]          iss_rd_i,
    input  logic                   flush_i,
    output logic                   stall_o
);

    localparam bit USE_BYPASS = (BYPASS != 0);

    logic [XLEN-1:0]  rf_view [NREGS];
    logic [NREGS-1:0] busy;

    rf_scoreboard #(
        .NREGS  (NREGS),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_valid_i (iss_valid_i),
        .set_addr_i  (iss_rd_i),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .flush_i     (flush_i),
        .busy_o      (busy)
    );

    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign rf_view[r] = '0;
        end else begin : g_store
            logic [XLEN-1:0] data_q;
            logic [XLEN-1:0] data_d;

            // Ascending scan so the highest-index write port wins a conflict.
            always_comb begin
                data_d = data_q;
                for (int i = 0; i < NUM_WR; i++) begin
                    if (wr_en_i[i] && (wr_addr_i[i*AW +: AW] == AW'(r))) begin
                        data_d = wr_data_i[i*XLEN +: XLEN];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                end else begin
                    data_q <= data_d;
                end
            end

            assign rf_view[r] = data_q;
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] fwd_data;
        logic            fwd_hit;

        assign addr = rd_addr_i[j*AW +: AW];

        always_comb begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_en_i[i] && (wr_addr_i[i*AW +: AW] == addr) && (addr != '0)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = wr_data_i[i*XLEN +: XLEN];
                end
            end
        end

        // Data landing this cycle resolves the hazard only when it is forwarded.
        assign rd_data_o[j*XLEN +: XLEN] = (USE_BYPASS && fwd_hit) ? fwd_data : rf_view[addr];
        assign rd_busy_o[j]              = busy[addr] && !(USE_BYPASS && fwd_hit);
    end

    always_comb begin
        stall_o = 1'b0;
        for (int j = 0; j < NUM_RD; j++) begin
            if (rd_busy_o[j] && (rd_addr_i[j*AW +: AW] != '0)) begin
                stall_o = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Self-checking bench: bypassing 2-write file and non-bypass 1-write file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;
    import rf_pkg::*;

    localparam int AW   = RF_AW;
    localparam int XL   = RF_XLEN;
    localparam int NRD  = 2;
    localparam int NWR  = 2;

    logic              clk;
    logic              rst_n;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*XL-1:0] rd_data_a;
    logic [NRD*XL-1:0] rd_data_b;
    logic [NRD-1:0]    rd_busy_a;
    logic [NRD-1:0]    rd_busy_b;
    logic [NWR-1:0]    wr_en;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*XL-1:0] wr_data;
    logic              iss_valid;
    rf_addr_t          iss_rd;
    logic              flush;
    logic              stall_a;
    logic              stall_b;

    int n_checks;
    int n_fail;

    // Reference state: A sees both write ports, B only port 0.
    logic [XL-1:0] m_reg_a [RF_NREGS];
    logic [XL-1:0] m_reg_b [RF_NREGS];
    bit            m_busy_a [RF_NREGS];
    bit            m_busy_b [RF_NREGS];

    regfile_mp #(.XLEN(XL), .NREGS(RF_NREGS), .NUM_RD(NRD), .NUM_WR(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a),
        .rd_busy_o(rd_busy_a), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .flush_i(flush), .stall_o(stall_a)
    );

    regfile_mp #(.XLEN(XL), .NREGS(RF_NREGS), .NUM_RD(NRD), .NUM_WR(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
        .rd_busy_o(rd_busy_b), .wr_en_i(wr_en[0:0]), .wr_addr_i(wr_addr[AW-1:0]),
        .wr_data_i(wr_data[XL-1:0]), .iss_valid_i(iss_valid), .iss_rd_i(iss_rd),
        .flush_i(flush), .stall_o(stall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        for (int r = 0; r < RF_NREGS; r++) begin
            m_reg_a[r]  = '0;
            m_reg_b[r]  = '0;
            m_busy_a[r] = 1'b0;
            m_busy_b[r] = 1'b0;
        end
    endtask

    task automatic model_update();
        rf_addr_t a;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NWR; i++) begin
            a = wr_addr[i*AW +: AW];
            if (wr_en[i] && a != 0) begin
                m_reg_a[a]  = wr_data[i*XL +: XL];
                m_busy_a[a] = 1'b0;
                if (i == 0) begin
                    m_reg_b[a]  = wr_data[XL-1:0];
                    m_busy_b[a] = 1'b0;
                end
            end
        end
        if (iss_valid && iss_rd != 0) begin
            m_busy_a[iss_rd] = 1'b1;
            m_busy_b[iss_rd] = 1'b1;
        end
        if (flush) begin
            for (int r = 0; r < RF_NREGS; r++) begin
                m_busy_a[r] = 1'b0;
                m_busy_b[r] = 1'b0;
            end
        end
    endtask

    function automatic logic [XL-1:0] exp_data(input bit sel_b, input int j);
        rf_addr_t      a;
        logic [XL-1:0] v;
        a = rd_addr[j*AW +: AW];
        if (a == 0) return '0;
        v = sel_b ? m_reg_b[a] : m_reg_a[a];
        if (!sel_b) begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_en[i] && wr_addr[i*AW +: AW] == a) v = wr_data[i*XL +: XL];
            end
        end
        return v;
    endfunction

    function automatic bit exp_busy(input bit sel_b, input int j);
        rf_addr_t a;
        bit       b;
        a = rd_addr[j*AW +: AW];
        if (a == 0) return 1'b0;
        b = sel_b ? m_busy_b[a] : m_busy_a[a];
        if (!sel_b) begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_en[i] && wr_addr[i*AW +: AW] == a) b = 1'b0;
            end
        end
        return b;
    endfunction

    function automatic bit exp_stall(input bit sel_b);
        bit s;
        s = 1'b0;
        for (int j = 0; j < NRD; j++) s = s | exp_busy(sel_b, j);
        return s;
    endfunction

    task automatic set_idle();
        rd_addr   = '0;
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        flush     = 1'b0;
    endtask

    task automatic set_rd(input int j, input int a);
        rd_addr[j*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int i, input int a, input logic [XL-1:0] d);
        wr_en[i]            = 1'b1;
        wr_addr[i*AW +: AW] = AW'(a);
        wr_data[i*XL +: XL] = d;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        set_rd(0, 5);
        set_rd(1, 9);
        #1;
        n_checks++;
        if (rd_data_a !== '0) begin
            n_fail++; $display("FAIL reset_data_a: got %h expected 0", rd_data_a);
        end
        n_checks++;
        if (rd_busy_a !== '0 || stall_a !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy_a: got busy %b stall %b expected 0 0", rd_busy_a, stall_a);
        end
        rst_n = 1'b1;
        step();
        set_idle();
        set_wr(0, 5, 32'hDEAD);
        step();
        set_idle();
        iss_valid = 1'b1;
        iss_rd    = 5'd5;
        step();
        set_idle();
        set_rd(0, 5);
        #1;
        n_checks++;
        if (rd_data_a[XL-1:0] !== 32'hDEAD || stall_a !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_x5: got %h stall %b expected 0000dead 1", rd_data_a[XL-1:0], stall_a);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (rd_data_a[XL-1:0] !== '0 || rd_data_b[XL-1:0] !== '0) begin
            n_fail++; $display("FAIL midrun_reset_data: got a %h b %h expected 0", rd_data_a[XL-1:0], rd_data_b[XL-1:0]);
        end
        n_checks++;
        if (stall_a !== 1'b0 || stall_b !== 1'b0) begin
            n_fail++; $display("FAIL midrun_reset_stall: got a %b b %b expected 0", stall_a, stall_b);
        end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_x0();
        set_idle();
        set_wr(0, 0, 32'hFFFF_FFFF);
        iss_valid = 1'b1;
        iss_rd    = '0;
        #1;
        n_checks++;
        if (rd_data_a[XL-1:0] !== '0 || stall_a !== 1'b0) begin
            n_fail++; $display("FAIL x0_same_cycle: got %h stall %b expected 0 0", rd_data_a[XL-1:0], stall_a);
        end
        step();
        set_idle();
        #1;
        n_checks++;
        if (rd_data_a !== '0 || rd_data_b !== '0 || rd_busy_a !== '0 || stall_b !== 1'b0) begin
            n_fail++; $display("FAIL x0_read: got a %h b %h busy %b expected 0", rd_data_a, rd_data_b, rd_busy_a);
        end
    endtask

    task automatic test_bypass();
        set_idle();
        set_wr(0, 7, 32'h1234);
        set_rd(0, 7);
        #1;
        n_checks++;
        if (rd_data_a[XL-1:0] !== 32'h1234) begin
            n_fail++; $display("FAIL bypass_on: got %h expected 00001234", rd_data_a[XL-1:0]);
        end
        n_checks++;
        if (rd_data_b[XL-1:0] !== 32'h0) begin
            n_fail++; $display("FAIL bypass_off_old: got %h expected 0", rd_data_b[XL-1:0]);
        end
        step();
        set_idle();
        set_rd(0, 7);
        #1;
        n_checks++;
        if (rd_data_b[XL-1:0] !== 32'h1234) begin
            n_fail++; $display("FAIL bypass_off_new: got %h expected 00001234", rd_data_b[XL-1:0]);
        end
    endtask

    task automatic test_load_use();
        set_idle();
        iss_valid = 1'b1;
        iss_rd    = 5'd3;
        step();
        set_idle();
        set_rd(1, 3);
        #1;
        n_checks++;
        if (stall_a !== 1'b1 || stall_b !== 1'b1 || rd_busy_a[1] !== 1'b1) begin
            n_fail++; $display("FAIL load_use_stall: got a %b b %b busy %b expected 1 1 1", stall_a, stall_b, rd_busy_a[1]);
        end
        set_wr(0, 3, 32'h55);
        #1;
        n_checks++;
        if (stall_a !== 1'b0 || rd_data_a[2*XL-1:XL] !== 32'h55) begin
            n_fail++; $display("FAIL load_use_bypass: got stall %b data %h expected 0 00000055", stall_a, rd_data_a[2*XL-1:XL]);
        end
        n_checks++;
        if (stall_b !== 1'b1) begin
            n_fail++; $display("FAIL load_use_nobypass: got stall %b expected 1", stall_b);
        end
        step();
        set_idle();
        set_rd(1, 3);
        #1;
        n_checks++;
        if (stall_b !== 1'b0 || rd_data_b[2*XL-1:XL] !== 32'h55) begin
            n_fail++; $display("FAIL load_use_retired: got stall %b data %h expected 0 00000055", stall_b, rd_data_b[2*XL-1:XL]);
        end
    endtask

    task automatic test_collision();
        set_idle();
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        step();
        set_idle();
        set_wr(0, 9, 32'h99);
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        step();
        set_idle();
        set_rd(0, 9);
        #1;
        n_checks++;
        if (rd_busy_a[0] !== 1'b1 || rd_busy_b[0] !== 1'b1) begin
            n_fail++; $display("FAIL set_beats_clear: got a %b b %b expected 1 1", rd_busy_a[0], rd_busy_b[0]);
        end
        set_wr(0, 9, 32'h9A);
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        flush     = 1'b1;
        step();
        set_idle();
        set_rd(0, 9);
        #1;
        n_checks++;
        if (rd_busy_a[0] !== 1'b0 || rd_busy_b[0] !== 1'b0 || stall_a !== 1'b0) begin
            n_fail++; $display("FAIL flush_wins: got a %b b %b stall %b expected 0 0 0", rd_busy_a[0], rd_busy_b[0], stall_a);
        end
    endtask

    task automatic test_port_conflict();
        set_idle();
        set_wr(0, 4, 32'hA);
        set_wr(1, 4, 32'hB);
        set_rd(0, 4);
        #1;
        n_checks++;
        if (rd_data_a[XL-1:0] !== 32'hB) begin
            n_fail++; $display("FAIL conflict_bypass: got %h expected 0000000b", rd_data_a[XL-1:0]);
        end
        step();
        set_idle();
        set_rd(0, 4);
        #1;
        n_checks++;
        if (rd_data_a[XL-1:0] !== 32'hB || rd_data_b[XL-1:0] !== 32'hA) begin
            n_fail++; $display("FAIL conflict_stored: got a %h b %h expected 0000000b 0000000a", rd_data_a[XL-1:0], rd_data_b[XL-1:0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NWR; i++) begin
                wr_en[i]            = ($urandom_range(0, 2) == 0);
                wr_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
                wr_data[i*XL +: XL] = XL'($urandom);
            end
            iss_valid = ($urandom_range(0, 3) == 0);
            iss_rd    = AW'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 31) == 0);
            for (int j = 0; j < NRD; j++) set_rd(j, int'($urandom_range(0, 7)));
            #1;
            for (int j = 0; j < NRD; j++) begin
                n_checks++;
                if (rd_data_a[j*XL +: XL] !== exp_data(1'b0, j)) begin
                    n_fail++; $display("FAIL rand_data_a c=%0d p=%0d: got %h expected %h", c, j, rd_data_a[j*XL +: XL], exp_data(1'b0, j));
                end
                n_checks++;
                if (rd_data_b[j*XL +: XL] !== exp_data(1'b1, j)) begin
                    n_fail++; $display("FAIL rand_data_b c=%0d p=%0d: got %h expected %h", c, j, rd_data_b[j*XL +: XL], exp_data(1'b1, j));
                end
                n_checks++;
                if (rd_busy_a[j] !== exp_busy(1'b0, j) || rd_busy_b[j] !== exp_busy(1'b1, j)) begin
                    n_fail++; $display("FAIL rand_busy c=%0d p=%0d: got a %b b %b expected %b %b", c, j, rd_busy_a[j], rd_busy_b[j], exp_busy(1'b0, j), exp_busy(1'b1, j));
                end
            end
            n_checks++;
            if (stall_a !== exp_stall(1'b0) || stall_b !== exp_stall(1'b1)) begin
                n_fail++; $display("FAIL rand_stall c=%0d: got a %b b %b expected %b %b", c, stall_a, stall_b, exp_stall(1'b0), exp_stall(1'b1));
            end
            step();
        end
        set_idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        set_idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_x0();
        test_bypass();
        test_load_use();
        test_collision();
        test_port_conflict();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
